// File: rtl/tpu_pkg.sv
// tpu_pkg: datapath defaults shared across the TPU blocks and the unified-buffer FSM states
package tpu_pkg;
  localparam int TPU_DATA_W = 8;
  localparam int TPU_LANES = 2;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} ub_state_t;
endpackage

// File: rtl/ub_stream_buffer_if.sv
// ub_stream_buffer_if: row-write, stream-command and skewed-stream signals of the unified buffer
interface ub_stream_buffer_if import tpu_pkg::*; #(
  parameter int DATA_W = TPU_DATA_W,
  parameter int LANES = TPU_LANES,
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [LANES-1:0]        wr_mask;
  logic [LANES*DATA_W-1:0] wr_data;
  logic                    start;
  logic [ADDR_W-1:0]       rd_base;
  logic [ADDR_W:0]         rd_len;
  logic [LANES-1:0]        rd_valid;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    busy;
  logic                    done;
  modport master (output wr_en, wr_addr, wr_mask, wr_data, start, rd_base, rd_len,
                  input rd_valid, rd_data, busy, done);
  modport slave (input wr_en, wr_addr, wr_mask, wr_data, start, rd_base, rd_len,
                 output rd_valid, rd_data, busy, done);
endinterface

// File: rtl/ub_skew_line.sv
// ub_skew_line: fixed-delay data+valid line; data is forced to zero whenever valid is low
module ub_skew_line #(
  parameter int DELAY = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  if (DELAY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid = in_valid;
    assign out_data = in_valid ? in_data : '0;
  end else begin : g_pipe
    logic [DELAY-1:0] v;
    logic [DELAY-1:0][DATA_W-1:0] d;
    always_ff @(posedge clk)
      if (rst) begin
        v <= '0;
        d <= '0;
      end else begin
        v[0] <= in_valid;
        d[0] <= in_valid ? in_data : '0;
        for (int i = 1; i < DELAY; i++) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
    assign out_valid = v[DELAY-1];
    assign out_data = d[DELAY-1];
  end
endmodule

// File: rtl/ub_stream_buffer.sv
// ub_stream_buffer: masked-write row buffer streaming a wrapping row range with per-lane diagonal skew
module ub_stream_buffer import tpu_pkg::*; #(
  parameter int DATA_W = TPU_DATA_W,
  parameter int LANES = TPU_LANES,
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  ub_stream_buffer_if.slave bus
);
  localparam int CNT_W = $clog2((DEPTH > LANES ? DEPTH : LANES) + 1);
  logic [LANES-1:0][DATA_W-1:0] mem [DEPTH];
  ub_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic done_q, done_d, len_ok;
  always_ff @(posedge clk)
    if (rst) for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    else if (bus.wr_en && 32'(bus.wr_addr) < DEPTH)
      for (int l = 0; l < LANES; l++)
        if (bus.wr_mask[l]) mem[bus.wr_addr][l] <= bus.wr_data[l*DATA_W +: DATA_W];
  assign len_ok = bus.rd_len != '0 && 32'(bus.rd_len) <= DEPTH;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  // done_q marks the trailing cycle after the skew has drained; busy covers it too
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start && !done_q && len_ok) begin
        state_d = STREAM;
        cnt_d = CNT_W'(bus.rd_len);
        addr_d = bus.rd_base;
      end
      STREAM: begin
        cnt_d = cnt_q - CNT_W'(1);
        addr_d = 32'(addr_q) == DEPTH - 1 ? '0 : addr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = LANES > 1 ? DRAIN : IDLE;
          cnt_d = CNT_W'(LANES - 1);
          done_d = LANES == 1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy = state_q != IDLE || done_q;
  assign bus.done = done_q;
  // lane 0 reads the array during the issue cycle; later lanes capture that read at the closing edge
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ub_skew_line #(.DELAY(l), .DATA_W(DATA_W)) u_skew (
      .clk(clk),
      .rst(rst),
      .in_valid(state_q == STREAM),
      .in_data(mem[addr_q][l]),
      .out_valid(bus.rd_valid[l]),
      .out_data(bus.rd_data[l*DATA_W +: DATA_W])
    );
  end
endmodule
